fc_layer_sequencer: RTL

//  Parametrised two-layer fully-connected sequencer; successor to the fixed 500/10 FC controller.

---
 rtl/fc_layer_sequencer.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/fc_layer_sequencer.sv
// Two-layer fully-connected sequencer: issues data/weight reads, steers the MAC
// through a RD_LAT-deep tag pipeline and packs each finished output into byte
// lanes of the banked E SRAMs (layer 1) or the F SRAM (layer 2).
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for start or a pending start
//   RUN1   | layer-1 reads, one per non-stalled cycle
//   DRAIN1 | no reads; waiting for the last layer-1 write
//   RUN2   | layer-2 reads from E
//   DRAIN2 | no reads; waiting for the last layer-2 write
module fc_layer_sequencer #(
    parameter int DATA_ADDR_WIDTH   = 10,
    parameter int WEIGHT_ADDR_WIDTH = 15,
    parameter int LANES             = 4,
    parameter int BANKS             = 5,
    parameter int L1_ROWS           = 40,
    parameter int L1_OUTS           = 500,
    parameter int L2_ROWS           = 25,
    parameter int L2_OUTS           = 10,
    parameter int RD_LAT            = 3
) (
    input  logic                         clk,
    input  logic                         srstn,
    input  logic                         start,
    input  logic                         mem_sel,
    input  logic                         stall,
    output logic                         busy,
    output logic                         layer,
    output logic [1:0]                   rd_src,
    output logic                         rd_en,
    output logic [DATA_ADDR_WIDTH-1:0]   data_raddr,
    output logic [WEIGHT_ADDR_WIDTH-1:0] weight_raddr,
    output logic                         mac_en,
    output logic                         acc_clear,
    output logic [BANKS-1:0]             wr_e_n,
    output logic                         wr_f_n,
    output logic [DATA_ADDR_WIDTH-1:0]   waddr,
    output logic [LANES-1:0]             bytemask,
    output logic                         fc1_done,
    output logic                         fc2_done
);

    localparam int MAX_OUTS = (L1_OUTS > L2_OUTS) ? L1_OUTS : L2_OUTS;
    localparam int J_W      = $clog2(MAX_OUTS + 1);
    localparam int LN_W     = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int BK_W     = (BANKS > 1) ? $clog2(BANKS) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN1   = 3'd1,
        DRAIN1 = 3'd2,
        RUN2   = 3'd3,
        DRAIN2 = 3'd4
    } state_t;

    state_t                      state;
    logic                        pending;
    logic [DATA_ADDR_WIDTH-1:0]  row;
    logic [J_W-1:0]              outj;
    logic [DATA_ADDR_WIDTH-1:0]  row_max;
    logic [J_W-1:0]              out_max;
    logic                        is_first;
    logic                        is_last;
    logic                        is_final;

    logic [RD_LAT-1:0]           p_val;
    logic [RD_LAT-1:0]           p_first;
    logic [RD_LAT-1:0]           p_last;
    logic [RD_LAT-1:0]           p_final;
    logic                        wr_sel;

    logic [LN_W-1:0]             wlane;
    logic [BK_W-1:0]             wbank;
    logic [DATA_ADDR_WIDTH-1:0]  wrow;

    assign row_max  = layer ? DATA_ADDR_WIDTH'(L2_ROWS - 1) : DATA_ADDR_WIDTH'(L1_ROWS - 1);
    assign out_max  = layer ? J_W'(L2_OUTS - 1) : J_W'(L1_OUTS - 1);
    assign is_first = (row == '0);
    assign is_last  = (row == row_max);
    assign is_final = is_last && (outj == out_max);

    // stall only suppresses issue; the tag pipeline keeps moving and carries a bubble
    assign rd_en      = ((state == RUN1) || (state == RUN2)) && !stall;
    assign busy       = (state != IDLE);
    assign data_raddr = row;
    assign mac_en     = p_val[RD_LAT-1];
    assign acc_clear  = p_val[RD_LAT-1] & p_first[RD_LAT-1];
    assign wr_sel     = p_val[RD_LAT-1] & p_last[RD_LAT-1];

    // sequencing FSM with row/output/weight scan counters and start bookkeeping
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            state        <= IDLE;
            pending      <= 1'b0;
            layer        <= 1'b0;
            rd_src       <= 2'd0;
            row          <= '0;
            outj         <= '0;
            weight_raddr <= '0;
        end else begin
            if (start && (state != IDLE)) begin
                pending <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start || pending) begin
                        state        <= RUN1;
                        pending      <= 1'b0;
                        layer        <= 1'b0;
                        rd_src       <= mem_sel ? 2'd0 : 2'd1;
                        row          <= '0;
                        outj         <= '0;
                        weight_raddr <= '0;
                    end
                end
                RUN1, RUN2: begin
                    if (!stall) begin
                        // layer-2 weights follow layer-1 weights, so one counter covers both
                        weight_raddr <= weight_raddr + WEIGHT_ADDR_WIDTH'(1);
                        if (is_last) begin
                            row <= '0;
                            if (is_final) begin
                                outj  <= '0;
                                state <= (state == RUN1) ? DRAIN1 : DRAIN2;
                            end else begin
                                outj <= outj + J_W'(1);
                            end
                        end else begin
                            row <= row + DATA_ADDR_WIDTH'(1);
                        end
                    end
                end
                DRAIN1: begin
                    // the final write implies every earlier tag has left the pipeline
                    if (fc1_done) begin
                        state  <= RUN2;
                        layer  <= 1'b1;
                        rd_src <= 2'd2;
                    end
                end
                DRAIN2: begin
                    if (fc2_done) begin
                        state <= IDLE;
                        layer <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // read-latency tag pipeline: one slot per cycle, bubbles when no read was issued
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            p_val   <= '0;
            p_first <= '0;
            p_last  <= '0;
            p_final <= '0;
        end else begin
            p_val[0]   <= rd_en;
            p_first[0] <= rd_en & is_first;
            p_last[0]  <= rd_en & is_last;
            p_final[0] <= rd_en & is_final;
            for (int i = 1; i < RD_LAT; i++) begin
                p_val[i]   <= p_val[i-1];
                p_first[i] <= p_first[i-1];
                p_last[i]  <= p_last[i-1];
                p_final[i] <= p_final[i-1];
            end
        end
    end

    // output packing: lane/bank/row counters replace division by LANES and BANKS
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            wr_e_n   <= '1;
            wr_f_n   <= 1'b1;
            waddr    <= '0;
            bytemask <= '0;
            fc1_done <= 1'b0;
            fc2_done <= 1'b0;
            wlane    <= '0;
            wbank    <= '0;
            wrow     <= '0;
        end else begin
            wr_e_n   <= '1;
            wr_f_n   <= 1'b1;
            bytemask <= '0;
            fc1_done <= 1'b0;
            fc2_done <= 1'b0;
            if (wr_sel) begin
                waddr <= wrow;
                for (int l = 0; l < LANES; l++) begin
                    bytemask[LANES-1-l] <= (int'(wlane) == l);
                end
                if (!layer) begin
                    for (int b = 0; b < BANKS; b++) begin
                        wr_e_n[b] <= (int'(wbank) != b);
                    end
                    fc1_done <= p_final[RD_LAT-1];
                end else begin
                    wr_f_n   <= 1'b0;
                    fc2_done <= p_final[RD_LAT-1];
                end
                if (p_final[RD_LAT-1]) begin
                    wlane <= '0;
                    wbank <= '0;
                    wrow  <= '0;
                end else if (wlane == LN_W'(LANES - 1)) begin
                    wlane <= '0;
                    // F is a single bank, so layer 2 advances the row on every lane wrap
                    if (layer || (wbank == BK_W'(BANKS - 1))) begin
                        wbank <= '0;
                        wrow  <= wrow + DATA_ADDR_WIDTH'(1);
                    end else begin
                        wbank <= wbank + BK_W'(1);
                    end
                end else begin
                    wlane <= wlane + LN_W'(1);
                end
            end
        end
    end

endmodule
